execute_pipe: RTL

- Parametrised LEGv8 execute stage that owns the EX/MEM pipeline register.
- It adds operand forwarding from MEM and WB, and an iterative multi-cycle multiplier (MUL) that stalls upstream stages while it runs.
- It sits between the ID/EX register and the memory stage of the pipelined datapath.
- All outputs toward MEM are registered.

---
 rtl/execute_pkg.sv | 31 +++
 rtl/execute_pipe_if.sv | 57 +++++
 rtl/execute_pipe_mul.sv | 92 +++++++++
 rtl/execute_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// -----------------------------------------------------------------------------
// execute_pkg
// Shared types for the LEGv8 execute stage:
//   alu_op_e    - AluControl encodings understood by the ALU / multiplier
//   fwd_sel_e   - ForwardA / ForwardB operand source selects (11 acts as 00)
//   mul_state_e - state of the iterative multiplier FSM
// -----------------------------------------------------------------------------
package execute_pkg;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SUB   = 4'b0110,
      ALU_PASSB = 4'b0111,
      ALU_MUL   = 4'b1000,
      ALU_NOR   = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mul_state_e;

endpackage

// File: rtl/execute_pipe_if.sv
// -----------------------------------------------------------------------------
// execute_pipe_if
// Bundle between the ID/EX register / hazard unit (master) and the execute
// stage (slave).
//   master drives: valid_in, flush, AluSrc, AluControl, PC_E, signImm_E,
//                  readData1_E, readData2_E, ForwardA, ForwardB,
//                  aluResult_M_fwd, result_W_fwd
//   slave drives:  stall_out, valid_M, PCBranch_M, aluResult_M, writeData_M,
//                  zero_M, mul_state (debug view of the multiplier FSM)
// Handshake: valid_in qualifies the ID/EX contents each cycle; when the slave
// raises stall_out the master must hold every ID/EX input unchanged for that
// cycle. valid_M qualifies the registered EX/MEM contents; there is no
// back-pressure from MEM.
// -----------------------------------------------------------------------------
interface execute_pipe_if #(
   parameter int N = 64
);
   import execute_pkg::*;

   logic         valid_in;
   logic         flush;
   logic         AluSrc;
   logic [3:0]   AluControl;
   logic [N-1:0] PC_E;
   logic [N-1:0] signImm_E;
   logic [N-1:0] readData1_E;
   logic [N-1:0] readData2_E;
   logic [1:0]   ForwardA;
   logic [1:0]   ForwardB;
   logic [N-1:0] aluResult_M_fwd;
   logic [N-1:0] result_W_fwd;

   logic         stall_out;
   logic         valid_M;
   logic [N-1:0] PCBranch_M;
   logic [N-1:0] aluResult_M;
   logic [N-1:0] writeData_M;
   logic         zero_M;
   mul_state_e   mul_state;

   modport master (
      output valid_in, flush, AluSrc, AluControl, PC_E, signImm_E,
             readData1_E, readData2_E, ForwardA, ForwardB,
             aluResult_M_fwd, result_W_fwd,
      input  stall_out, valid_M, PCBranch_M, aluResult_M, writeData_M,
             zero_M, mul_state
   );

   modport slave (
      input  valid_in, flush, AluSrc, AluControl, PC_E, signImm_E,
             readData1_E, readData2_E, ForwardA, ForwardB,
             aluResult_M_fwd, result_W_fwd,
      output stall_out, valid_M, PCBranch_M, aluResult_M, writeData_M,
             zero_M, mul_state
   );

endinterface

// File: rtl/execute_pipe_mul.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Radix-2 shift-add multiplier, one partial product per clock, N iterations.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start_i          - accept a, b (only looked at in IDLE)
//   flush_i          - abort: back to IDLE, counter cleared
//   a_i, b_i         - operands, latched on acceptance
//   busy_o           - FSM is in BUSY
//   last_o           - final iteration this cycle (cnt == N-1)
//   product_next_o   - accumulator plus the current partial product; on the
//                      last cycle this is the low N bits of a*b
//   state_o          - FSM state (debug)
// -----------------------------------------------------------------------------
module seq_multiplier
   import execute_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic         flush_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         busy_o,
   output logic         last_o,
   output logic [N-1:0] product_next_o,
   output mul_state_e   state_o
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   mul_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [N-1:0] acc_q, acc_d;

   assign busy_o         = (state_q == BUSY);
   assign last_o         = busy_o && (cnt_q == CNT_LAST);
   assign product_next_o = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
   assign state_o        = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = BUSY;
               a_d     = a_i;
               b_d     = b_i;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            acc_d = product_next_o;
            cnt_d = cnt_q + CW'(1);
            if (last_o) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // An abort wins over any iteration in progress, including the last one.
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/execute_pipe.sv
// -----------------------------------------------------------------------------
// execute_pipe
// LEGv8 execute stage owning the EX/MEM register: operand forwarding from
// MEM/WB, single-cycle ALU, branch-target adder and an optional iterative
// multiplier that stalls upstream for N cycles.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - execute_pipe_if.slave (ID/EX inputs, forwarding values,
//                stall_out and the registered EX/MEM outputs)
// Parameters:
//   N      - datapath width
//   MUL_EN - 1 builds the multiplier; 0 executes the MUL code as ADD
// -----------------------------------------------------------------------------
module execute_pipe
   import execute_pkg::*;
#(
   parameter int N      = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   execute_pipe_if.slave bus
);

   logic [N-1:0] fa, fb, op_b, alu_res, pc_branch, mul_product;
   logic         is_mul, mul_start, mul_busy, mul_last, stall;
   mul_state_e   mul_state;

   logic         valid_q, valid_d, zero_q, zero_d;
   logic [N-1:0] alu_q, alu_d, wd_q, wd_d, pcb_q, pcb_d;

   // Forwarding muxes; select 11 falls back to the register file value.
   always_comb begin
      case (bus.ForwardA)
         FWD_MEM: fa = bus.aluResult_M_fwd;
         FWD_WB:  fa = bus.result_W_fwd;
         default: fa = bus.readData1_E;
      endcase
      case (bus.ForwardB)
         FWD_MEM: fb = bus.aluResult_M_fwd;
         FWD_WB:  fb = bus.result_W_fwd;
         default: fb = bus.readData2_E;
      endcase
   end

   assign op_b      = bus.AluSrc ? bus.signImm_E : fb;
   assign pc_branch = bus.PC_E + (bus.signImm_E << 2);
   assign is_mul    = (MUL_EN != 1'b0) && (bus.AluControl == ALU_MUL);

   always_comb begin
      alu_res = '0;
      case (bus.AluControl)
         ALU_AND:   alu_res = fa & op_b;
         ALU_OR:    alu_res = fa | op_b;
         ALU_ADD:   alu_res = fa + op_b;
         ALU_SUB:   alu_res = fa - op_b;
         ALU_PASSB: alu_res = op_b;
         ALU_NOR:   alu_res = ~(fa | op_b);
         // With the multiplier present this code never reaches EX/MEM via the ALU.
         ALU_MUL:   alu_res = (MUL_EN != 1'b0) ? '0 : fa + op_b;
         default:   alu_res = '0;
      endcase
   end

   // Stall covers the acceptance cycle and every BUSY cycle but the last,
   // so the ID/EX inputs are still valid when the product is written back.
   assign stall = !reset && !bus.flush &&
                  ((mul_busy && !mul_last) || (!mul_busy && bus.valid_in && is_mul));
   assign mul_start = bus.valid_in && is_mul && !mul_busy && !bus.flush;

   generate
      if (MUL_EN) begin : g_mul
         seq_multiplier #(.N(N)) u_mul (
            .clk            (clk),
            .reset          (reset),
            .start_i        (mul_start),
            .flush_i        (bus.flush),
            .a_i            (fa),
            .b_i            (op_b),
            .busy_o         (mul_busy),
            .last_o         (mul_last),
            .product_next_o (mul_product),
            .state_o        (mul_state)
         );
      end else begin : g_no_mul
         assign mul_busy    = 1'b0;
         assign mul_last    = 1'b0;
         assign mul_product = '0;
         assign mul_state   = IDLE;
      end
   endgenerate

   // EX/MEM next state: bubbles keep the data fields, only valid drops.
   always_comb begin
      valid_d = 1'b0;
      alu_d   = alu_q;
      zero_d  = zero_q;
      wd_d    = wd_q;
      pcb_d   = pcb_q;
      if (bus.flush || stall) begin
         valid_d = 1'b0;
      end else if (mul_busy) begin
         valid_d = 1'b1;
         alu_d   = mul_product;
         zero_d  = (mul_product == '0);
         wd_d    = fb;
         pcb_d   = pc_branch;
      end else if (bus.valid_in) begin
         valid_d = 1'b1;
         alu_d   = alu_res;
         zero_d  = (alu_res == '0);
         wd_d    = fb;
         pcb_d   = pc_branch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         zero_q  <= 1'b0;
         wd_q    <= '0;
         pcb_q   <= '0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         zero_q  <= zero_d;
         wd_q    <= wd_d;
         pcb_q   <= pcb_d;
      end
   end

   assign bus.stall_out   = stall;
   assign bus.valid_M     = valid_q;
   assign bus.aluResult_M = alu_q;
   assign bus.zero_M      = zero_q;
   assign bus.writeData_M = wd_q;
   assign bus.PCBranch_M  = pcb_q;
   assign bus.mul_state   = mul_state;

endmodule
